// File: rtl/sobel_window_gen_pkg.sv
// Shared types and default sizes for the 3x3 Sobel window generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sobel_window_gen_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int PIX_W_DEF      = 16;
    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 64;

    // Counter widths for the default frame geometry
    localparam int COL_W = $clog2(IMG_WIDTH_DEF);
    localparam int ROW_W = $clog2(IMG_HEIGHT_DEF);

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage, indexed by column.
// Latency: asynchronous read; write lands on the next clock edge (read-before-write).
// Backpressure: none, the caller writes only on accepted pixels.
module sobel_line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Old contents are visible during the write cycle, so a row can be shifted down
    assign rd_data = mem[addr];

    // Store the new pixel for this column
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window generator feeding the gradient stage.
// Latency: 1 clock from accepted pixel to start/window (and to frame_done).
// Backpressure: none; push-only input, pixels outside a frame without sof are dropped.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] im11,
    output logic [PIX_W-1:0] im12,
    output logic [PIX_W-1:0] im13,
    output logic [PIX_W-1:0] im21,
    output logic [PIX_W-1:0] im22,
    output logic [PIX_W-1:0] im23,
    output logic [PIX_W-1:0] im31,
    output logic [PIX_W-1:0] im32,
    output logic [PIX_W-1:0] im33,
    output logic             start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CB = $clog2(IMG_WIDTH);
    localparam int RB = $clog2(IMG_HEIGHT);
    localparam logic [CB-1:0] COL_LAST = CB'(IMG_WIDTH - 1);
    localparam logic [RB-1:0] ROW_LAST = RB'(IMG_HEIGHT - 1);
    localparam logic [CB-1:0] COL_TWO  = CB'(2);
    localparam logic [RB-1:0] ROW_TWO  = RB'(2);

    state_t           state;
    state_t           state_nxt;
    logic [CB-1:0]    col;
    logic [RB-1:0]    row;
    logic [CB-1:0]    cur_col;
    logic [RB-1:0]    cur_row;
    logic             restart;
    logic             accept;
    logic             last_pix;
    logic             emit;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] col_new [3];
    logic [PIX_W-1:0] col_m1  [3];
    logic [PIX_W-1:0] col_m2  [3];
    logic [PIX_W-1:0] win     [3][3];

    // sof on a valid pixel always starts a fresh frame at (0,0), even mid-frame
    assign restart  = pix_valid && sof;
    assign accept   = pix_valid && (sof || (state == ACTIVE));
    assign cur_col  = restart ? '0 : col;
    assign cur_row  = restart ? '0 : row;
    assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    assign emit     = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    assign busy     = (state == ACTIVE);

    // lb0 holds the previous row, lb1 the row before; lb1 is refilled from lb0
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CB)) u_lb0 (
        .clk     (clk),
        .addr    (cur_col),
        .wr_en   (accept),
        .wr_data (pix_in),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CB)) u_lb1 (
        .clk     (clk),
        .addr    (cur_col),
        .wr_en   (accept),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: any accepted pixel keeps the frame open unless it is the last one
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (restart) state_nxt = ACTIVE;
            ACTIVE:  if (accept && last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position of the next expected pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= last_pix ? '0 : cur_row + RB'(1);
            end else begin
                col <= cur_col + CB'(1);
                row <= cur_row;
            end
        end
    end

    // Right-hand column of the window as seen by the current pixel
    always_comb begin
        col_new[0] = lb1_rd;
        col_new[1] = lb0_rd;
        col_new[2] = pix_in;
    end

    // Column history shifts on every accepted pixel; the visible window only on emission
    always_ff @(posedge clk) begin
        if (reset) begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                col_m1[r] <= '0;
                col_m2[r] <= '0;
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            start      <= emit;
            frame_done <= accept && last_pix;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    col_m2[r] <= col_m1[r];
                    col_m1[r] <= col_new[r];
                end
            end
            if (emit) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= col_m2[r];
                    win[r][1] <= col_m1[r];
                    win[r][2] <= col_new[r];
                end
            end
        end
    end

    assign im11 = win[0][0];
    assign im12 = win[0][1];
    assign im13 = win[0][2];
    assign im21 = win[1][0];
    assign im22 = win[1][1];
    assign im23 = win[1][2];
    assign im31 = win[2][0];
    assign im32 = win[2][1];
    assign im33 = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 frame: image-array reference model plus scoreboard.
// Latency: expects outputs one clock after each driven cycle.
// Backpressure: none; stimulus drives on negedge, monitor samples 1ns after posedge.
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 16;

    typedef logic [9*PW-1:0] win_t;
    typedef struct packed {
        logic st;
        logic fd;
        logic bsy;
        logic zero;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [PW-1:0] im11, im12, im13, im21, im22, im23, im31, im32, im33;
    logic          start, frame_done, busy;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .im11       (im11),
        .im12       (im12),
        .im13       (im13),
        .im21       (im21),
        .im22       (im22),
        .im23       (im23),
        .im31       (im31),
        .im32       (im32),
        .im33       (im33),
        .start      (start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    exp_t    exp_q[$];
    win_t    win_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      n_start = 0;
    int      n_fd = 0;
    int      cyc = 0;
    win_t    first_win = '0;
    win_t    last_win = '0;

    // Reference model: frame position, open/closed, and the image seen so far
    bit            m_active = 1'b0;
    int            m_r = 0;
    int            m_c = 0;
    logic [PW-1:0] img [H][W];

    function automatic win_t dut_win();
        return {im11, im12, im13, im21, im22, im23, im31, im32, im33};
    endfunction

    // Window whose top-left pixel is tl in an image of value tl + r*W + c
    function automatic win_t grid_win(input int tl);
        win_t w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(8 - (i*3 + j))*PW +: PW] = PW'(tl + i*W + j);
        return w;
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_win(input string name, input win_t act, input win_t req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // One stimulus cycle: drive inputs, update the model, queue expectations
    task automatic drive(input bit v, input logic [PW-1:0] p, input bit s, input bit rst);
        exp_t e;
        win_t w;
        bit   lst;
        bit   emit;
        @(negedge clk);
        reset = rst;
        pix_valid = v;
        pix_in = p;
        sof = s;
        e = '0;
        if (rst) begin
            m_active = 1'b0;
            m_r = 0;
            m_c = 0;
            e.zero = 1'b1;
        end else if (v && (m_active || s)) begin
            if (s) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = p;
            emit = (m_r >= 2) && (m_c >= 2);
            lst  = (m_r == H-1) && (m_c == W-1);
            if (emit) begin
                w = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w[(8 - (i*3 + j))*PW +: PW] = img[m_r-2+i][m_c-2+j];
                win_q.push_back(w);
            end
            m_active = !lst;
            if (m_c == W-1) begin
                m_c = 0;
                m_r = lst ? 0 : m_r + 1;
            end else begin
                m_c++;
            end
            e.st = emit;
            e.fd = lst;
            e.bsy = m_active;
        end else begin
            e.bsy = m_active;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    // gap_mode: 0 continuous, 1 two idle cycles after each pixel, 2 random gaps
    task automatic send_frame(input bit rnd, input int base, input int gap_mode);
        logic [PW-1:0] p;
        for (int k = 0; k < W*H; k++) begin
            p = rnd ? PW'($urandom_range(0, 65535)) : PW'(base + k);
            drive(1'b1, p, k == 0, 1'b0);
            if (gap_mode == 1) idle(2);
            else if (gap_mode == 2) idle($urandom_range(0, 2));
        end
    endtask

    task automatic new_test();
        n_start = 0;
        n_fd = 0;
    endtask

    // Monitor: one expectation per driven cycle; windows popped on every start
    initial begin
        exp_t me;
        win_t mw;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                n_cmp++;
                if ({start, frame_done, busy} !== {me.st, me.fd, me.bsy}) begin
                    n_err++;
                    $display("FAIL ctl cyc%0d: start/frame_done/busy got %b%b%b, want %b%b%b",
                             cyc, start, frame_done, busy, me.st, me.fd, me.bsy);
                end
                if (me.zero) check_win("reset_window", dut_win(), '0);
            end
            if (start === 1'b1) begin
                n_start++;
                if (win_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL window cyc%0d: unexpected start, window %h", cyc, dut_win());
                end else begin
                    mw = win_q.pop_front();
                    check_win("window", dut_win(), mw);
                end
                if (n_start == 1) first_win = dut_win();
                last_win = dut_win();
            end
            if (frame_done === 1'b1) n_fd++;
        end
    end

    initial begin
        // Reset state
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, 16'd7, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // 1: continuous ramp frame
        new_test();
        send_frame(1'b0, 0, 0);
        idle(3);
        check_int("t1_windows", n_start, 4);
        check_int("t1_frame_done", n_fd, 1);
        check_win("t1_first", first_win, grid_win(0));
        check_win("t1_last", last_win, grid_win(5));

        // 2: same frame with valid gaps
        new_test();
        send_frame(1'b0, 0, 1);
        idle(3);
        check_int("t2_windows", n_start, 4);
        check_win("t2_first", first_win, grid_win(0));
        check_win("t2_last", last_win, grid_win(5));

        // 3: stray pixels in IDLE are dropped
        new_test();
        drive(1'b1, 16'd99, 1'b0, 1'b0);
        drive(1'b1, 16'd99, 1'b0, 1'b0);
        drive(1'b1, 16'd99, 1'b0, 1'b0);
        send_frame(1'b0, 0, 0);
        idle(3);
        check_int("t3_windows", n_start, 4);
        check_win("t3_first", first_win, grid_win(0));

        // 4: sof at pixel 7 aborts the frame
        new_test();
        for (int k = 0; k < 7; k++) drive(1'b1, PW'(k), k == 0, 1'b0);
        send_frame(1'b0, 100, 0);
        idle(3);
        check_int("t4_windows", n_start, 4);
        check_int("t4_frame_done", n_fd, 1);
        check_win("t4_first", first_win, grid_win(100));

        // 5: reset at pixel 11, later pixels ignored until sof
        new_test();
        for (int k = 0; k < 11; k++) drive(1'b1, PW'(k), k == 0, 1'b0);
        drive(1'b1, 16'd11, 1'b0, 1'b1);
        for (int k = 12; k < 16; k++) drive(1'b1, PW'(k), 1'b0, 1'b0);
        idle(3);
        check_int("t5_windows", n_start, 1);
        check_int("t5_frame_done", n_fd, 0);

        // 6: back-to-back random frames
        new_test();
        send_frame(1'b1, 0, 0);
        send_frame(1'b1, 0, 0);
        idle(3);
        check_int("t6_windows", n_start, 8);
        check_int("t6_frame_done", n_fd, 2);

        // 7: random pixels with random gaps
        new_test();
        send_frame(1'b1, 0, 2);
        idle(3);
        check_int("t7_windows", n_start, 4);
        check_int("t7_frame_done", n_fd, 1);

        idle(2);
        check_int("leftover_windows", win_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
